// File: rtl/cpu_run_monitor.sv
// Run controller/monitor for an RV32I core: sequences core reset, counts RUN
// cycles and retired instructions, and stops the run on a tohost store, a PC
// self-loop (hang) or an exhausted cycle budget. All outputs are registered.
module cpu_run_monitor #(
  parameter int              XLEN         = 32,
  parameter int              CNT_W        = 32,
  parameter int              RESET_CYCLES = 4,
  parameter int              MAX_CYCLES   = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_0100,
  parameter int              HANG_LIMIT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             instr_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             hang,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [XLEN-1:0]  last_pc
);

  localparam int               HCW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HCW-1:0]   HOLD_LAST = HCW'(RESET_CYCLES - 1);
  localparam logic [HCW-1:0]   HOLD_ONE  = HCW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] HANG_CNT  = CNT_W'(HANG_LIMIT);
  localparam logic [XLEN-1:0]  PASS_CODE = XLEN'(1);
  localparam logic             HANG_EN   = (HANG_LIMIT != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  state_e           state_q, state_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] hang_cnt_q, hang_cnt_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [XLEN-1:0]  exit_code_q, exit_code_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             hang_q, hang_d;
  logic             timeout_q, timeout_d;
  logic             tohost_s, hang_hit_s, time_hit_s;

  // Next-state and next-output logic for the IDLE/HOLD/RUN/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    instr_count_d = instr_count_q;
    hang_cnt_d    = hang_cnt_q;
    last_pc_d     = last_pc_q;
    exit_code_d   = exit_code_q;
    cpu_reset_d   = cpu_reset_q;
    busy_d        = busy_q;
    done_d        = done_q;
    pass_d        = pass_q;
    fail_d        = fail_q;
    hang_d        = hang_q;
    timeout_d     = timeout_q;
    tohost_s      = 1'b0;
    hang_hit_s    = 1'b0;
    time_hit_s    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new run starts from a clean slate, whether from IDLE or DONE.
        if (start) begin
          state_d       = ST_HOLD;
          hold_cnt_d    = '0;
          cycle_count_d = '0;
          instr_count_d = '0;
          hang_cnt_d    = '0;
          last_pc_d     = '0;
          exit_code_d   = '0;
          cpu_reset_d   = 1'b1;
          busy_d        = 1'b1;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          hang_d        = 1'b0;
          timeout_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end

      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = ST_RUN;
          hold_cnt_d  = '0;
          cpu_reset_d = 1'b0;
        end else begin
          hold_cnt_d  = hold_cnt_q + HOLD_ONE;
        end
      end

      ST_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        if (instr_valid) begin
          instr_count_d = sat_inc(instr_count_q);
          last_pc_d     = pc;
          if (pc == last_pc_q) begin
            hang_cnt_d = sat_inc(hang_cnt_q);
          end else begin
            hang_cnt_d = '0;
          end
        end else begin
          hang_cnt_d = hang_cnt_q;
        end

        tohost_s   = mem_we && (mem_addr == TOHOST_ADDR);
        // Only a retirement that actually bumps the counter can reach the limit.
        hang_hit_s = HANG_EN && instr_valid && (pc == last_pc_q) && (hang_cnt_d == HANG_CNT);
        time_hit_s = (cycle_count_d == MAX_CNT);

        // Exit priority: tohost, then hang, then timeout; exactly one flag.
        if (tohost_s) begin
          exit_code_d = mem_wdata;
          pass_d      = (mem_wdata == PASS_CODE);
          fail_d      = (mem_wdata != PASS_CODE);
        end else if (hang_hit_s) begin
          hang_d      = 1'b1;
        end else if (time_hit_s) begin
          timeout_d   = 1'b1;
        end else begin
          exit_code_d = exit_code_q;
        end

        if (tohost_s || hang_hit_s || time_hit_s) begin
          state_d     = ST_DONE;
          cpu_reset_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cpu_reset_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      instr_count_q <= '0;
      hang_cnt_q    <= '0;
      last_pc_q     <= '0;
      exit_code_q   <= '0;
      cpu_reset_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      hang_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
      hang_cnt_q    <= hang_cnt_d;
      last_pc_q     <= last_pc_d;
      exit_code_q   <= exit_code_d;
      cpu_reset_q   <= cpu_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      hang_q        <= hang_d;
      timeout_q     <= timeout_d;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign hang        = hang_q;
  assign timeout     = timeout_q;
  assign exit_code   = exit_code_q;
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
  assign last_pc     = last_pc_q;

endmodule
